// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination feeds the ID instruction forces one bubble and freezes PC and IF/ID.
module idex_hazard_reg #(
  parameter int DATA_W = 16,
  parameter int INST_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [INST_W-1:0] inst_curr_IFID,
  input  logic [DATA_W-1:0] rdata1_id,
  input  logic [DATA_W-1:0] rdata2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [3:0]        alu_op_id,
  input  logic              alu_src_id,
  input  logic              rf_wen_id,
  input  logic              mem2reg_id,
  input  logic              dmem_wen_id,
  output logic [INST_W-1:0] inst_curr_IDEX,
  output logic [DATA_W-1:0] rdata1_idex,
  output logic [DATA_W-1:0] rdata2_idex,
  output logic [DATA_W-1:0] imm_idex,
  output logic [3:0]        alu_op_idex,
  output logic              alu_src_idex,
  output logic              rf_wen_idex,
  output logic              mem2reg_idex,
  output logic              dmem_wen_idex,
  output logic              valid_idex,
  output logic              pc_wen,
  output logic              ifid_wen,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              rf_wen;
    logic              mem2reg;
    logic              dmem_wen;
    logic              valid;
  } idex_t;

  // Bubble has rd=0 so downstream forwarding can never match it.
  localparam idex_t BUBBLE = '{
    inst: '0, rdata1: '0, rdata2: '0, imm: '0, alu_op: '0,
    alu_src: 1'b0, rf_wen: 1'b0, mem2reg: 1'b1, dmem_wen: 1'b1, valid: 1'b0
  };

  idex_t             idex_q, idex_d, idex_in;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        rd_ex;
  logic              lu;

  assign idex_in = '{
    inst: inst_curr_IFID, rdata1: rdata1_id, rdata2: rdata2_id, imm: imm_id,
    alu_op: alu_op_id, alu_src: alu_src_id, rf_wen: rf_wen_id,
    mem2reg: mem2reg_id, dmem_wen: dmem_wen_id, valid: 1'b1
  };

  assign rd_ex = idex_q.inst[11:8];
  assign lu = idex_q.rf_wen && !idex_q.mem2reg && idex_q.valid && (rd_ex != 4'd0) &&
              ((rd_ex == inst_curr_IFID[7:4]) || (rd_ex == inst_curr_IFID[3:0]) ||
               ((rd_ex == inst_curr_IFID[11:8]) && !dmem_wen_id));

  assign pc_wen   = !hold && !(lu && !flush);
  assign ifid_wen = pc_wen;

  always_comb begin
    // NOTE: defaulting every next-state to the current state first keeps this block latch-free.
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (!hold) begin
      if (flush) begin
        idex_d = BUBBLE;
      end else if (lu) begin
        idex_d = BUBBLE;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        idex_d = idex_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      idex_q <= BUBBLE;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign inst_curr_IDEX = idex_q.inst;
  assign rdata1_idex    = idex_q.rdata1;
  assign rdata2_idex    = idex_q.rdata2;
  assign imm_idex       = idex_q.imm;
  assign alu_op_idex    = idex_q.alu_op;
  assign alu_src_idex   = idex_q.alu_src;
  assign rf_wen_idex    = idex_q.rf_wen;
  assign mem2reg_idex   = idex_q.mem2reg;
  assign dmem_wen_idex  = idex_q.dmem_wen;
  assign valid_idex     = idex_q.valid;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Randomised and directed bench for idex_hazard_reg against a rule-level model.
// A second instance with a 2-bit counter exercises saturation alongside the default one.
module tb_idex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush;
  logic [15:0] inst_curr_IFID, rdata1_id, rdata2_id, imm_id;
  logic [3:0]  alu_op_id;
  logic        alu_src_id, rf_wen_id, mem2reg_id, dmem_wen_id;

  logic [15:0] inst_curr_IDEX, rdata1_idex, rdata2_idex, imm_idex;
  logic [3:0]  alu_op_idex;
  logic        alu_src_idex, rf_wen_idex, mem2reg_idex, dmem_wen_idex, valid_idex;
  logic        pc_wen, ifid_wen;
  logic [15:0] stall_cnt;

  logic [15:0] s_inst, s_r1, s_r2, s_imm;
  logic [3:0]  s_op;
  logic        s_src, s_rfw, s_m2r, s_dwen, s_valid, s_pc_wen, s_ifid_wen;
  logic [1:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the instruction currently sitting in EX, and the total bubble count.
  logic [15:0] m_inst, m_r1, m_r2, m_imm;
  logic [3:0]  m_op;
  logic        m_src, m_rfw, m_m2r, m_dwen, m_valid;
  int          m_cnt;

  always #5 clk = ~clk;

  idex_hazard_reg #(.DATA_W(16), .INST_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .inst_curr_IFID(inst_curr_IFID), .rdata1_id(rdata1_id), .rdata2_id(rdata2_id),
    .imm_id(imm_id), .alu_op_id(alu_op_id), .alu_src_id(alu_src_id),
    .rf_wen_id(rf_wen_id), .mem2reg_id(mem2reg_id), .dmem_wen_id(dmem_wen_id),
    .inst_curr_IDEX(inst_curr_IDEX), .rdata1_idex(rdata1_idex), .rdata2_idex(rdata2_idex),
    .imm_idex(imm_idex), .alu_op_idex(alu_op_idex), .alu_src_idex(alu_src_idex),
    .rf_wen_idex(rf_wen_idex), .mem2reg_idex(mem2reg_idex), .dmem_wen_idex(dmem_wen_idex),
    .valid_idex(valid_idex), .pc_wen(pc_wen), .ifid_wen(ifid_wen), .stall_cnt(stall_cnt)
  );

  idex_hazard_reg #(.DATA_W(16), .INST_W(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .inst_curr_IFID(inst_curr_IFID), .rdata1_id(rdata1_id), .rdata2_id(rdata2_id),
    .imm_id(imm_id), .alu_op_id(alu_op_id), .alu_src_id(alu_src_id),
    .rf_wen_id(rf_wen_id), .mem2reg_id(mem2reg_id), .dmem_wen_id(dmem_wen_id),
    .inst_curr_IDEX(s_inst), .rdata1_idex(s_r1), .rdata2_idex(s_r2),
    .imm_idex(s_imm), .alu_op_idex(s_op), .alu_src_idex(s_src),
    .rf_wen_idex(s_rfw), .mem2reg_idex(s_m2r), .dmem_wen_idex(s_dwen),
    .valid_idex(s_valid), .pc_wen(s_pc_wen), .ifid_wen(s_ifid_wen), .stall_cnt(s_cnt)
  );

  function automatic logic [163:0] obs();
    return {inst_curr_IDEX, rdata1_idex, rdata2_idex, imm_idex, alu_op_idex, alu_src_idex,
            rf_wen_idex, mem2reg_idex, dmem_wen_idex, valid_idex, stall_cnt,
            s_inst, s_r1, s_r2, s_imm, s_op, s_src, s_rfw, s_m2r, s_dwen, s_valid, s_cnt};
  endfunction

  function automatic logic [163:0] expv();
    logic [72:0] f;
    logic [15:0] c16;
    logic [1:0]  c2;
    f   = {m_inst, m_r1, m_r2, m_imm, m_op, m_src, m_rfw, m_m2r, m_dwen, m_valid};
    c16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    c2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    return {f, c16, f, c2};
  endfunction

  // A load in EX whose nonzero destination is read by the ID instruction.
  function automatic bit m_lu();
    logic [3:0] rd;
    rd = m_inst[11:8];
    if (!(m_valid && m_rfw && !m_m2r) || rd == 4'd0) return 1'b0;
    return rd == inst_curr_IFID[7:4] || rd == inst_curr_IFID[3:0] ||
           (rd == inst_curr_IFID[11:8] && !dmem_wen_id);
  endfunction

  function automatic logic [3:0] comb_obs();
    return {pc_wen, ifid_wen, s_pc_wen, s_ifid_wen};
  endfunction

  function automatic logic [3:0] comb_exp();
    bit adv;
    adv = !hold && !(m_lu() && !flush);
    return {4{adv}};
  endfunction

  task automatic m_bubble();
    {m_inst, m_r1, m_r2, m_imm, m_op, m_src, m_rfw} = '0;
    m_m2r = 1'b1; m_dwen = 1'b1; m_valid = 1'b0;
  endtask

  task automatic tick();
    if (!rst_n) begin
      m_bubble(); m_cnt = 0;
    end else if (!hold) begin
      if (flush) m_bubble();
      else if (m_lu()) begin m_bubble(); m_cnt++; end
      else begin
        m_inst = inst_curr_IFID; m_r1 = rdata1_id; m_r2 = rdata2_id; m_imm = imm_id;
        m_op = alu_op_id; m_src = alu_src_id; m_rfw = rf_wen_id;
        m_m2r = mem2reg_id; m_dwen = dmem_wen_id; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] inst, input logic rfw, input logic m2r, input logic dwen);
    hold = 1'b0; flush = 1'b0;
    inst_curr_IFID = inst;
    rdata1_id = 16'($urandom); rdata2_id = 16'($urandom); imm_id = 16'($urandom);
    alu_op_id = 4'($urandom); alu_src_id = 1'($urandom);
    rf_wen_id = rfw; mem2reg_id = m2r; dmem_wen_id = dwen;
  endtask

  task automatic rand_inputs();
    drive({4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
          1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      hold = 1'($urandom); flush = 1'($urandom);
      tick();
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL reset_regs: got %h want %h", obs(), expv()); end
    end
    vectors++;
    if ({valid_idex, mem2reg_idex, dmem_wen_idex, rf_wen_idex, stall_cnt} !== {4'b0110, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got %b %b %b %b %h want 0 1 1 0 0000", valid_idex, mem2reg_idex,
               dmem_wen_idex, rf_wen_idex, stall_cnt);
    end
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b1, 1'b1);
    #1;
    vectors++;
    if (comb_obs() !== 4'b1111) begin miscompares++; $display("FAIL reset_pc_wen: got %b want 1111", comb_obs()); end
  endtask

  task automatic test_passthrough();
    logic [15:0] inst;
    inst = {4'($urandom), 12'h312};
    drive(inst, 1'b1, 1'b1, 1'b1);
    rdata1_id = 16'h00AA; rdata2_id = 16'h0055;
    #1;
    vectors++;
    if (comb_obs() !== comb_exp()) begin miscompares++; $display("FAIL pass_pc_wen: got %b want %b", comb_obs(), comb_exp()); end
    tick();
    vectors++;
    if (obs() !== expv()) begin miscompares++; $display("FAIL pass_regs: got %h want %h", obs(), expv()); end
    vectors++;
    if ({inst_curr_IDEX, rdata1_idex, rdata2_idex, valid_idex} !== {inst, 16'h00AA, 16'h0055, 1'b1}) begin
      miscompares++;
      $display("FAIL pass_fields: got %h %h %h %b want %h 00aa 0055 1", inst_curr_IDEX, rdata1_idex,
               rdata2_idex, valid_idex, inst);
    end
  endtask

  // Load into rd, then a consumer; returns with the consumer still in IF/ID and the load in EX.
  task automatic load_then(input logic [3:0] rd, input logic [15:0] use_inst, input logic use_dwen);
    drive({4'hB, rd, 8'h00}, 1'b1, 1'b0, 1'b1);
    tick();
    drive(use_inst, !use_dwen ? 1'b0 : 1'b1, 1'b1, use_dwen);
    #1;
  endtask

  task automatic test_load_use();
    logic [15:0] add_inst;
    add_inst = {4'h1, 12'h541};
    load_then(4'd4, add_inst, 1'b1);
    vectors++;
    if (comb_obs() !== 4'b0000) begin miscompares++; $display("FAIL lu_stall: got %b want 0000", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || valid_idex !== 1'b0) begin
      miscompares++; $display("FAIL lu_bubble: got %h want %h", obs(), expv());
    end
    #1;
    vectors++;
    if (comb_obs() !== 4'b1111) begin miscompares++; $display("FAIL lu_release: got %b want 1111", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || inst_curr_IDEX !== add_inst || valid_idex !== 1'b1) begin
      miscompares++; $display("FAIL lu_add: got %h want %h", obs(), expv());
    end
    vectors++;
    if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_count: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_store_source();
    load_then(4'd6, 16'h2678, 1'b0);
    vectors++;
    if (comb_obs() !== 4'b0000) begin miscompares++; $display("FAIL sw_stall: got %b want 0000", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || valid_idex !== 1'b0) begin
      miscompares++; $display("FAIL sw_bubble: got %h want %h", obs(), expv());
    end
    tick();
    vectors++;
    if (obs() !== expv() || inst_curr_IDEX !== 16'h2678 || stall_cnt !== 16'd2) begin
      miscompares++; $display("FAIL sw_proceed: got %h want %h", obs(), expv());
    end
    load_then(4'd0, 16'h2078, 1'b0);
    vectors++;
    if (comb_obs() !== 4'b1111) begin miscompares++; $display("FAIL sw_r0_nostall: got %b want 1111", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || inst_curr_IDEX !== 16'h2078 || stall_cnt !== 16'd2) begin
      miscompares++; $display("FAIL sw_r0_proceed: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_priority();
    logic [15:0]  cnt_before;
    logic [163:0] snap;
    load_then(4'd4, 16'h1541, 1'b1);
    flush = 1'b1;
    cnt_before = stall_cnt;
    #1;
    vectors++;
    if (comb_obs() !== 4'b1111) begin miscompares++; $display("FAIL flush_pc_wen: got %b want 1111", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || valid_idex !== 1'b0 || stall_cnt !== cnt_before) begin
      miscompares++; $display("FAIL flush_bubble: got %h want %h", obs(), expv());
    end
    load_then(4'd4, 16'h1541, 1'b1);
    hold = 1'b1;
    snap = obs();
    cnt_before = stall_cnt;
    #1;
    vectors++;
    if (comb_obs() !== 4'b0000) begin miscompares++; $display("FAIL hold_pc_wen: got %b want 0000", comb_obs()); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs() !== snap || obs() !== expv()) begin
        miscompares++; $display("FAIL hold_frozen: got %h want %h", obs(), snap);
      end
    end
    hold = 1'b0;
    #1;
    vectors++;
    if (comb_obs() !== 4'b0000) begin miscompares++; $display("FAIL hold_resume: got %b want 0000", comb_obs()); end
    tick();
    vectors++;
    if (obs() !== expv() || valid_idex !== 1'b0 || stall_cnt !== cnt_before + 16'd1) begin
      miscompares++; $display("FAIL hold_bubble: got %h want %h", obs(), expv());
    end
    tick();
    vectors++;
    if (obs() !== expv() || inst_curr_IDEX !== 16'h1541) begin
      miscompares++; $display("FAIL hold_add: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      load_then(4'd4, 16'h1541, 1'b1);
      tick();
      tick();
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL sat_pair%0d: got %h want %h", i, obs(), expv()); end
    end
    vectors++;
    if (s_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_value: got %0d want 3", s_cnt); end
    load_then(4'd4, 16'h1541, 1'b1);
    vectors++;
    if (comb_obs() !== 4'b0000) begin miscompares++; $display("FAIL sat_midstall: got %b want 0000", comb_obs()); end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (obs() !== expv() || stall_cnt !== 16'd0 || s_cnt !== 2'd0 || valid_idex !== 1'b0) begin
      miscompares++; $display("FAIL sat_reset: got %h want %h", obs(), expv());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit frozen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if (!frozen) rand_inputs();
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      frozen = rst_n && (comb_exp() == 4'b0000);
      if (rst_n) begin
        vectors++;
        if (comb_obs() !== comb_exp()) begin
          miscompares++; $display("FAIL rand_comb[%0d]: got %b want %b", i, comb_obs(), comb_exp());
        end
      end
      tick();
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL rand_regs[%0d]: got %h want %h", i, obs(), expv()); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_store_source();
    test_priority();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
